score_tracker: RTL and testbench

SCORE_TRACKER -- requirements
Module: score_tracker

---
 rtl/score_tracker.sv | 143 ++++++++++++++
 tb/tb_score_tracker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_tracker.sv
// Tracks the highest-scoring cell of a QUERY_LEN x DB_LEN score matrix streamed in raster order.
// It also counts the cells flagged as zero, then holds the result until the consumer accepts it.
module score_tracker #(
    parameter int SCORE_WIDTH  = 8,
    parameter int SOURCE_WIDTH = 2,
    parameter int QUERY_LEN    = 16,
    parameter int DB_LEN       = 16,
    localparam int ROW_WIDTH   = $clog2(QUERY_LEN),
    localparam int COL_WIDTH   = $clog2(DB_LEN),
    localparam int CNT_WIDTH   = $clog2(QUERY_LEN*DB_LEN+1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SCORE_WIDTH-1:0]  score,
    input  logic                    zero_score_bit,
    input  logic [SOURCE_WIDTH-1:0] source,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SCORE_WIDTH-1:0]  max_score,
    output logic [ROW_WIDTH-1:0]    max_row,
    output logic [COL_WIDTH-1:0]    max_col,
    output logic [SOURCE_WIDTH-1:0] max_source,
    output logic [CNT_WIDTH-1:0]    zero_count,
    output logic                    busy
);

    localparam int CELLS = QUERY_LEN * DB_LEN;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REPORT  = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_busy;
    logic [SCORE_WIDTH-1:0]  r_max_score;
    logic [ROW_WIDTH-1:0]    r_max_row;
    logic [COL_WIDTH-1:0]    r_max_col;
    logic [SOURCE_WIDTH-1:0] r_max_source;
    logic [CNT_WIDTH-1:0]    r_zero_count;
    logic [ROW_WIDTH-1:0]    r_row;
    logic [COL_WIDTH-1:0]    r_col;

    logic w_accept;
    logic w_last_col;
    logic w_last_row;
    logic w_zero_sat;

    // in_ready is only ever high in COLLECT, so acceptance implies COLLECT.
    assign w_accept   = in_valid && r_in_ready;
    assign w_last_col = (r_col == COL_WIDTH'(DB_LEN - 1));
    assign w_last_row = (r_row == ROW_WIDTH'(QUERY_LEN - 1));
    assign w_zero_sat = (r_zero_count == CNT_WIDTH'(CELLS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_max_score  <= '0;
            r_max_row    <= '0;
            r_max_col    <= '0;
            r_max_source <= '0;
            r_zero_count <= '0;
            r_row        <= '0;
            r_col        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_COLLECT;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_max_score  <= '0;
                        r_max_row    <= '0;
                        r_max_col    <= '0;
                        r_max_source <= '0;
                        r_zero_count <= '0;
                        r_row        <= '0;
                        r_col        <= '0;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        // Strict compare keeps the earliest cell on ties.
                        if (score > r_max_score) begin
                            r_max_score  <= score;
                            r_max_row    <= r_row;
                            r_max_col    <= r_col;
                            r_max_source <= source;
                        end
                        if (zero_score_bit && !w_zero_sat) begin
                            r_zero_count <= r_zero_count + CNT_WIDTH'(1);
                        end
                        if (w_last_col) begin
                            r_col <= '0;
                            if (w_last_row) begin
                                r_row       <= '0;
                                r_state     <= S_REPORT;
                                r_in_ready  <= 1'b0;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_row <= r_row + ROW_WIDTH'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_WIDTH'(1);
                        end
                    end
                end
                S_REPORT: begin
                    if (r_out_valid && out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign max_score  = r_max_score;
    assign max_row    = r_max_row;
    assign max_col    = r_max_col;
    assign max_source = r_max_source;
    assign zero_count = r_zero_count;

endmodule

// File: tb/tb_score_tracker.sv
// Directed checks of score_tracker on a 4x4 matrix: peak, tie, gaps with backpressure,
// all-zero, reset mid-run and start pulses while busy.
module tb_score_tracker;

    localparam int SW = 8;
    localparam int RW = 2;
    localparam int CW = 2;
    localparam int NW = 5;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] score;
    logic          zero_score_bit;
    logic [1:0]    source;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] max_score;
    logic [RW-1:0] max_row;
    logic [CW-1:0] max_col;
    logic [1:0]    max_source;
    logic [NW-1:0] zero_count;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    logic [SW-1:0] m_score [16];
    logic [1:0]    m_src   [16];

    score_tracker #(
        .SCORE_WIDTH (SW),
        .SOURCE_WIDTH(2),
        .QUERY_LEN   (4),
        .DB_LEN      (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .score         (score),
        .zero_score_bit(zero_score_bit),
        .source        (source),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .max_score     (max_score),
        .max_row       (max_row),
        .max_col       (max_col),
        .max_source    (max_source),
        .zero_count    (zero_count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [31:0] e_score, input logic [31:0] e_row,
                              input logic [31:0] e_col, input logic [31:0] e_src, input logic [31:0] e_zc);
        chk({tag, ".max_score"},  32'(max_score),  e_score);
        chk({tag, ".max_row"},    32'(max_row),    e_row);
        chk({tag, ".max_col"},    32'(max_col),    e_col);
        chk({tag, ".max_source"}, 32'(max_source), e_src);
        chk({tag, ".zero_count"}, 32'(zero_count), e_zc);
        $display("step %s: score=%0h row=%0d col=%0d src=%0d zc=%0d ov=%0b busy=%0b",
                 tag, max_score, max_row, max_col, max_source, zero_count, out_valid, busy);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_peak();
        for (int i = 0; i < 16; i++) begin
            m_score[i] = 8'h00;
            m_src[i]   = 2'(i);
        end
        m_score[9] = 8'h07;
        m_src[9]   = 2'd2;
    endtask

    task automatic load_tie();
        for (int i = 0; i < 16; i++) begin
            m_score[i] = 8'h01;
            m_src[i]   = 2'(i);
        end
        m_score[3]  = 8'h0A;
        m_score[12] = 8'h0A;
    endtask

    task automatic load_zero();
        for (int i = 0; i < 16; i++) begin
            m_score[i] = 8'h00;
            m_src[i]   = 2'(3 - (i % 4));
        end
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy"},     32'(busy),     32'd1);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk_result({tag, ".clear"}, 0, 0, 0, 0, 0);
    endtask

    // Feeds cells 0..n-1; optional random gaps; raises start alongside cell pulse_at.
    task automatic run_matrix(input string tag, input int n, input bit gaps, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(1, 0) == 0; g++) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            chk($sformatf("%s.in_ready%0d", tag, i), 32'(in_ready), 32'd1);
            if (i == 15) chk({tag, ".ov_early"}, 32'(out_valid), 32'd0);
            in_valid       = 1'b1;
            score          = m_score[i];
            zero_score_bit = (m_score[i] == 8'h00);
            source         = m_src[i];
            if (i == pulse_at) start = 1'b1;
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; score = '0;
        zero_score_bit = 1'b0; source = '0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd0);
        chk("rst.busy",      32'(busy),      32'd0);
        chk_result("rst", 0, 0, 0, 0, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single peak at cell 9
        load_peak();
        do_start("peak");
        run_matrix("peak", 16, 1'b0, -1);
        chk("peak.out_valid", 32'(out_valid), 32'd1);
        chk_result("peak", 8'h07, 2, 1, 2, 15);
        tick();
        chk("peak.idle_ov",   32'(out_valid), 32'd0);
        chk("peak.idle_busy", 32'(busy),      32'd0);
        // in_valid in IDLE must not touch the held result
        in_valid = 1'b1; score = 8'hFF; zero_score_bit = 1'b0; source = 2'd3;
        tick(); tick();
        in_valid = 1'b0;
        chk_result("peak.hold", 8'h07, 2, 1, 2, 15);

        // Tie: earliest cell wins
        load_tie();
        do_start("tie");
        run_matrix("tie", 16, 1'b0, -1);
        chk("tie.out_valid", 32'(out_valid), 32'd1);
        chk_result("tie", 8'h0A, 0, 3, 3, 0);
        tick();

        // Gaps plus backpressure
        load_peak();
        out_ready = 1'b0;
        do_start("bp");
        run_matrix("bp", 16, 1'b1, -1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp.ov%0d", k), 32'(out_valid), 32'd1);
            chk_result($sformatf("bp.hold%0d", k), 8'h07, 2, 1, 2, 15);
            tick();
        end
        out_ready = 1'b1;
        chk("bp.ov_last", 32'(out_valid), 32'd1);
        tick();
        chk("bp.idle_ov",   32'(out_valid), 32'd0);
        chk("bp.idle_busy", 32'(busy),      32'd0);

        // All-zero matrix
        load_zero();
        do_start("zero");
        run_matrix("zero", 16, 1'b0, -1);
        chk("zero.out_valid", 32'(out_valid), 32'd1);
        chk_result("zero", 0, 0, 0, 0, 16);
        tick();

        // Reset after 6 accepted cells of the tie matrix
        load_tie();
        do_start("mid");
        run_matrix("mid", 6, 1'b0, -1);
        chk_result("mid.part", 8'h0A, 0, 3, 3, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.rst_ov",   32'(out_valid), 32'd0);
        chk("mid.rst_rdy",  32'(in_ready),  32'd0);
        chk("mid.rst_busy", 32'(busy),      32'd0);
        chk_result("mid.rst", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid.quiet_ov%0d", k),   32'(out_valid), 32'd0);
            chk($sformatf("mid.quiet_busy%0d", k), 32'(busy),      32'd0);
        end
        load_peak();
        do_start("fresh");
        run_matrix("fresh", 16, 1'b0, -1);
        chk("fresh.out_valid", 32'(out_valid), 32'd1);
        chk_result("fresh", 8'h07, 2, 1, 2, 15);
        tick();

        // Start pulses while busy are ignored
        load_tie();
        out_ready = 1'b0;
        do_start("sb");
        run_matrix("sb", 16, 1'b0, 5);
        chk("sb.out_valid", 32'(out_valid), 32'd1);
        chk_result("sb", 8'h0A, 0, 3, 3, 0);
        start = 1'b1;
        tick();
        chk("sb.rep_ov",   32'(out_valid), 32'd1);
        chk("sb.rep_busy", 32'(busy),      32'd1);
        chk_result("sb.rep", 8'h0A, 0, 3, 3, 0);
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("sb.exit_ov",   32'(out_valid), 32'd0);
        chk("sb.exit_busy", 32'(busy),      32'd0);
        tick();
        chk("sb.stay_busy", 32'(busy),     32'd0);
        chk("sb.stay_rdy",  32'(in_ready), 32'd0);
        chk_result("sb.stay", 8'h0A, 0, 3, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
